bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//   Multi-cycle N-bit adder: accepts two WIDTH-bit operands over a valid/ready
//   handshake and adds them LSB-first, one bit per clock. Each bit uses a full
//   adder built from two half_adder cells, plus a registered carry.
//   Presents the WIDTH-bit sum and carry-out on a valid/ready output handshake.
//   Serves as the sequential consumer of the half_adder cell in the arithmetic
//   IP set, and as the next verification target after it.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 1..32
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands on in_a/in_b are valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   in_a       in   WIDTH  operand A, unsigned
//   in_b       in   WIDTH  operand B, unsigned
//   out_valid  out  1      out_sum/out_carry hold a completed result
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  WIDTH  (in_a + in_b) mod 2^WIDTH
//   out_carry  out  1      carry-out of the MSB, i.e. bit WIDTH of the sum
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, carry reg=0, bit count=0,
//   shift regs=0, out_sum=0, out_carry=0.
//   While rst=1: in_ready=0, out_valid=0, busy=0. in_valid during reset is ignored.
// - FSM states: IDLE, RUN, DONE. Outputs are decoded from registered state only.
//   No combinational path from in_valid/out_ready to any output.
// - IDLE: in_ready=1.
//   On in_valid&&in_ready: load A_sr=in_a, B_sr=in_b, carry=0, cnt=0; go to RUN.
// - RUN: in_ready=0, busy=1. Each cycle: {c,s}=A_sr[0]+B_sr[0]+carry.
//   Then A_sr and B_sr shift right by 1, and s shifts into S_sr[WIDTH-1]
//   (S_sr shifts right). carry<=c, cnt<=cnt+1.
//   When cnt==WIDTH-1, the same edge goes to DONE.
// - DONE: out_valid=1. out_sum=S_sr and out_carry=carry, both held stable
//   until out_valid&&out_ready; then go to IDLE.
//   in_ready=0 in DONE: no overlap, so a new operand cannot be accepted on the
//   same edge as the result handshake.
// - Latency: accept at edge k; out_valid first high after edge k+WIDTH.
//   Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
// - WIDTH=1: exactly one RUN cycle. cnt is $clog2(WIDTH+1) bits wide;
//   cnt never wraps, since the RUN exit occurs at WIDTH-1.
// - Backpressure: out_ready low holds DONE indefinitely with outputs frozen.
//   in_valid is ignored while in RUN or DONE.
// - Reset mid-operation (RUN or DONE): abort. The next cycle is IDLE with all
//   reset values, and no partial result is ever presented.
// - out_sum/out_carry hold their last value after the handshake until
//   overwritten; consumers qualify them with out_valid only.
// STRUCTURE
// - Package adder_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} bsa_state_t;
//   and localparam MAX_WIDTH=32.
// - Sub-module full_adder (a, b, cin -> sum, cout): two half_adder instances
//   plus an OR of their carries. Instantiate it once in bit_serial_adder.
// - Top: FSM, cnt, A_sr/B_sr/S_sr shift registers, carry flop; no other logic.
// TESTING (WIDTH=8 unless stated; out_ready=1 unless stated)
// 1. Zero: 0x00+0x00 -> out_valid 8 cycles after accept, out_sum=0x00,
//    out_carry=0; in_ready=1 again one cycle after the handshake.
// 2. Full ripple: 0xFF+0x01 -> out_sum=0x00, out_carry=1.
//    Also 0xFF+0xFF -> out_sum=0xFE, out_carry=1.
// 3. Backpressure: 0xA5+0x5A with out_ready=0 for 5 cycles after out_valid ->
//    out_sum=0xFF and out_carry=0 stay stable, in_ready=0 throughout.
//    A second in_valid during that window is not accepted.
// 4. Reset mid-RUN: assert rst for 1 cycle, 3 cycles after accepting
//    0x12+0x34 -> IDLE, out_valid never rises for that op.
//    Then 0x80+0x80 -> out_sum=0x00, out_carry=1.
// 5. WIDTH=1: 1+1 -> out_sum=0, out_carry=1, out_valid 1 cycle after accept;
//    0+1 -> out_sum=1, out_carry=0.
// 6. Random: 1000 ops with random in_valid/out_ready gaps, WIDTH=8 and WIDTH=32,
//    checked against a scoreboard of {out_carry,out_sum}==a+b. Cover in_valid
//    asserted during reset (ignored) and the back-to-back accept at WIDTH+2 spacing.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder and its arithmetic cells.
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} bsa_state_t;
  localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/full_adder.sv
// Full adder composed of two half_adder cells; the carries can never both be set.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell: sum = a ^ b, carry = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: operands shift through one full adder, one bit per clock,
// with the sum assembled in a right-shifting register and a registered carry.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  bsa_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        s_sr_d            = s_sr_q >> 1;
        s_sr_d[WIDTH-1]   = fa_sum;
        carry_d           = fa_cout;
        cnt_d             = cnt_q + 1'b1;
        // The last bit is summed on the same edge that leaves RUN, so cnt stops at WIDTH.
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
    end
  end

  // Handshake outputs come from registered state only; rst masks them while held.
  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = !rst && (state_q == DONE);
  assign busy      = !rst && ((state_q == RUN) || (state_q == DONE));
  assign out_sum   = s_sr_q;
  assign out_carry = carry_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder at WIDTH=8, 32 and 1: vector table, hand-written
// corner sequences and randomized ops scored against plain a+b arithmetic.
module tb_bit_serial_adder;
  logic        clk;
  logic        rst;
  logic [2:0]  iv, ir, ov, ordy, oc, bz;
  logic [7:0]  a8, b8, s8;
  logic [31:0] a32, b32, s32;
  logic        a1, b1, s1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] sb_q[$];

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(a8), .in_b(b8),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s8), .out_carry(oc[0]), .busy(bz[0]));
  bit_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(a32), .in_b(b32),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s32), .out_carry(oc[1]), .busy(bz[1]));
  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(a1), .in_b(b1),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s1), .out_carry(oc[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 32 : 1;
  endfunction

  function automatic logic [63:0] get_sum(int idx);
    case (idx)
      0:       return {56'b0, s8};
      1:       return {32'b0, s32};
      default: return {63'b0, s1};
    endcase
  endfunction

  function automatic logic [63:0] get_result(int idx);
    return (64'(oc[idx]) << wid(idx)) | get_sum(idx);
  endfunction

  function automatic logic [63:0] model_add(int idx, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask;
    mask = (64'd1 << wid(idx)) - 64'd1;
    return (64'(a) & mask) + (64'(b) & mask);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic set_ops(int idx, logic [31:0] a, logic [31:0] b);
    case (idx)
      0:       begin a8 = a[7:0]; b8 = b[7:0]; end
      1:       begin a32 = a; b32 = b; end
      default: begin a1 = a[0]; b1 = b[0]; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept(int idx, logic [31:0] a, logic [31:0] b);
    int n;
    set_ops(idx, a, b);
    iv[idx] = 1'b1;
    n = 0;
    while (!ir[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[idx]) timeout("accept");
    @(negedge clk);
    iv[idx] = 1'b0;
  endtask

  task automatic wait_ov(int idx, output int lat);
    lat = 0;
    while (!ov[idx] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!ov[idx]) timeout("wait_out_valid");
  endtask

  initial begin
    int lat, n;
    bit seen;
    logic [31:0] ra, rb;

    rst = 1'b1; iv = '0; ordy = 3'b111;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0; a1 = 1'b0; b1 = 1'b0;

    // Reset with in_valid asserted: nothing accepted, handshakes held low.
    set_ops(0, 32'h11, 32'h22);
    iv[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(ir), 64'd0);
    check("rst_out_valid", 64'(ov), 64'd0);
    check("rst_busy", 64'(bz), 64'd0);
    check("rst_sum8", get_result(0), 64'd0);
    rst = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(bz), 64'd0);
    check("post_rst_in_ready", 64'(ir), 64'd7);

    vecs[0] = '{0, 32'h00, 32'h00, 64'h000};
    vecs[1] = '{0, 32'hFF, 32'h01, 64'h100};
    vecs[2] = '{0, 32'hFF, 32'hFF, 64'h1FE};
    vecs[3] = '{0, 32'hA5, 32'h5A, 64'h0FF};
    vecs[4] = '{2, 32'h1, 32'h1, 64'h2};
    vecs[5] = '{2, 32'h0, 32'h1, 64'h1};
    vecs[6] = '{1, 32'hFFFF_FFFF, 32'h1, 64'h1_0000_0000};
    vecs[7] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0_ACF1_3568};

    foreach (vecs[i]) begin
      accept(vecs[i].idx, vecs[i].a, vecs[i].b);
      wait_ov(vecs[i].idx, lat);
      check("vec_latency", 64'(lat), 64'(wid(vecs[i].idx)));
      check("vec_result", get_result(vecs[i].idx), vecs[i].exp);
      @(negedge clk);
      check("vec_ov_drop", 64'(ov[vecs[i].idx]), 64'd0);
      check("vec_in_ready_back", 64'(ir[vecs[i].idx]), 64'd1);
    end

    // Backpressure: result frozen, second request ignored.
    ordy[0] = 1'b0;
    accept(0, 32'hA5, 32'h5A);
    wait_ov(0, lat);
    set_ops(0, 32'h01, 32'h02);
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(ov[0]), 64'd1);
      check("bp_result", get_result(0), 64'h0FF);
      check("bp_in_ready", 64'(ir[0]), 64'd0);
      @(negedge clk);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_release_ov", 64'(ov[0]), 64'd0);
    @(negedge clk);
    check("bp_no_second_op", 64'(bz[0]), 64'd0);

    // Reset three cycles into RUN aborts the op.
    accept(0, 32'h12, 32'h34);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ov[0]) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_out_valid", 64'(seen), 64'd0);
    check("abort_busy", 64'(bz[0]), 64'd0);
    check("abort_cleared", get_result(0), 64'd0);
    accept(0, 32'h80, 32'h80);
    wait_ov(0, lat);
    check("after_abort_result", get_result(0), 64'h100);
    @(negedge clk);

    // Back-to-back with in_valid held: initiation interval WIDTH+2.
    set_ops(0, 32'h03, 32'h04);
    iv[0] = 1'b1;
    wait_ov(0, lat);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[0] && n < 50);
    iv[0] = 1'b0;
    check("b2b_interval", 64'(n), 64'd10);
    check("b2b_result", get_result(0), 64'h007);
    repeat (2) @(negedge clk);
    check("b2b_idle", 64'(bz[0]), 64'd0);

    // Randomized ops with gaps and out_ready stalls.
    for (int idx = 0; idx < 2; idx++) begin
      for (int k = 0; k < 500; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ra = $urandom;
        rb = $urandom;
        sb_q.push_back(model_add(idx, ra, rb));
        accept(idx, ra, rb);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
          ordy[idx] = ($urandom_range(0, 2) != 0);
          if (ov[idx] && ordy[idx]) begin
            check("rand_result", get_result(idx), sb_q.pop_front());
            seen = 1'b1;
          end
          @(negedge clk);
          n++;
        end
        if (!seen) begin
          timeout("rand_result");
          void'(sb_q.pop_front());
        end
        ordy[idx] = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
